// File: rtl/video_timing.sv
// rtl/video_timing.sv - free-running raster timing: x/y counters, syncs, visible window, vblank irq, frame count
module video_timing #(
  parameter int H_VISIBLE   = 320,
  parameter int H_FRONT     = 8,
  parameter int H_SYNC      = 48,
  parameter int H_BACK      = 24,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LINE_REPEAT = 2,
  parameter int GAME_W      = 256,
  parameter int GAME_H      = 240
) (
  input  logic       gpu_clk,
  input  logic       rst,
  input  logic       irq_ack,
  output logic [8:0] current_x,
  output logic [8:0] current_y,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       vblank_irq,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int REP_W   = $clog2(LINE_REPEAT);

  localparam logic [8:0]       H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0]       HS_START = 9'(H_VISIBLE + H_FRONT);
  localparam logic [8:0]       HS_END   = 9'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]       VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [8:0]       GW       = 9'(GAME_W);
  localparam logic [8:0]       GH       = 9'(GAME_H);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(LINE_REPEAT - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  logic [9:0]       vga_line;
  logic [REP_W-1:0] rep_cnt;

  logic [8:0]       h_nxt;
  logic [8:0]       y_nxt;
  logic [9:0]       line_nxt;
  logic [REP_W-1:0] rep_nxt;
  logic             line_adv;
  logic             frame_wrap;
  logic             irq_set;

  // Outputs are decoded from the next counter values so every output lands on the same edge.
  always_comb begin
    line_adv   = (current_x == H_LAST);
    frame_wrap = line_adv && (vga_line == V_LAST);
    h_nxt      = line_adv ? 9'd0 : current_x + 9'd1;
    line_nxt   = vga_line;
    rep_nxt    = rep_cnt;
    y_nxt      = current_y;
    if (frame_wrap) begin
      line_nxt = '0;
      rep_nxt  = '0;
      y_nxt    = '0;
    end else if (line_adv) begin
      line_nxt = vga_line + 10'd1;
      if (rep_cnt == REP_LAST) begin
        rep_nxt = '0;
        y_nxt   = current_y + 9'd1;
      end else begin
        rep_nxt = rep_cnt + REP_ONE;
      end
    end
    irq_set = (h_nxt == 9'd0) && (y_nxt == GH) && (rep_nxt == '0);
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      current_x   <= '0;
      current_y   <= '0;
      vga_line    <= '0;
      rep_cnt     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      visible     <= 1'b1;
      vblank_irq  <= 1'b0;
      frame_count <= '0;
    end else begin
      current_x <= h_nxt;
      current_y <= y_nxt;
      vga_line  <= line_nxt;
      rep_cnt   <= rep_nxt;
      hsync     <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
      vsync     <= !((line_nxt >= VS_START) && (line_nxt < VS_END));
      visible   <= (h_nxt < GW) && (y_nxt < GH);
      // A new vblank request outranks an acknowledge arriving on the same edge.
      if (irq_set) begin
        vblank_irq <= 1'b1;
      end else if (irq_ack) begin
        vblank_irq <= 1'b0;
      end
      if (frame_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
